// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
//   Bundles the two requester ports (core "c_*", debug/loader "d_*"), the
//   single synchronous memory port ("mem_*") and the arbiter status outputs.
//
//   Modports:
//     slave  - the arbiter: consumes requests and mem_rdata, produces grants,
//              responses, the memory strobes and busy/owner.
//     master - the environment (core, debug port, memory): the mirror image.
//
//   Requester signals (per port x in {c, d}):
//     x_req, x_we, x_addr, x_wstrb, x_wdata   request and payload
//     x_gnt                                   one-cycle accept pulse
//     x_rvalid, x_rdata                       one-cycle response, read data
//   Memory signals:
//     mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_rdata
//   Status:
//     busy   transaction in flight
//     owner  0 = core, 1 = debug; port of current or last transaction
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  c_req;
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [STRB_WIDTH-1:0] c_wstrb;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_gnt;
  logic                  c_rvalid;
  logic [DATA_WIDTH-1:0] c_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [STRB_WIDTH-1:0] d_wstrb;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;
  logic                  owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wstrb, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wstrb, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata,
    output busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wstrb, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wstrb, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata,
    input  busy, owner
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one unified instruction/data memory between the core and the
//   debug/loader port. Every access runs IDLE -> ACCESS -> RESPOND; a new
//   request seen in RESPOND goes straight back to ACCESS, so back-to-back
//   traffic sustains one access every two cycles. Ties are broken
//   round-robin against the port granted last.
//
//   Ports:
//     clk    sole clock, rising edge
//     reset  asynchronous, active-low
//     bus    memory_arbiter_if.slave: both requester ports, memory port,
//            busy/owner status
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  memory_arbiter_if.slave   bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Memory is word addressed; the two low byte-address bits are dropped.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  state_t state;
  state_t state_nx;

  // last_grant: 1 = debug was granted most recently.
  logic                  last_grant;
  logic                  owner_q;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [STRB_WIDTH-1:0] lat_wstrb;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic any_req;
  logic pick_dbg;
  logic can_arb;
  logic take;

  // Requests are only looked at in IDLE and RESPOND; anything raised during
  // ACCESS is invisible unless still held into RESPOND.
  assign any_req  = bus.c_req | bus.d_req;
  assign pick_dbg = (bus.c_req & bus.d_req) ? ~last_grant : bus.d_req;
  assign can_arb  = (state == IDLE) || (state == RESPOND);
  assign take     = can_arb & any_req;

  assign bus.owner = owner_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Reset leaves last_grant on debug so the core wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wstrb  <= '0;
      lat_wdata  <= '0;
    end else if (take) begin
      last_grant <= pick_dbg;
      owner_q    <= pick_dbg;
      lat_we     <= pick_dbg ? bus.d_we    : bus.c_we;
      lat_addr   <= pick_dbg ? bus.d_addr  : bus.c_addr;
      lat_wstrb  <= pick_dbg ? bus.d_wstrb : bus.c_wstrb;
      lat_wdata  <= pick_dbg ? bus.d_wdata : bus.c_wdata;
    end
  end

  // All outputs are decoded from the registered state, so an asynchronous
  // reset clears them at once and a pending memory write is never issued.
  always_comb begin
    state_nx      = state;
    bus.c_gnt     = 1'b0;
    bus.c_rvalid  = 1'b0;
    bus.c_rdata   = '0;
    bus.d_gnt     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wstrb = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;

    case (state)
      IDLE: begin
        if (take) begin
          state_nx = ACCESS;
        end
      end

      ACCESS: begin
        bus.busy      = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_we    = lat_we;
        bus.mem_addr  = lat_addr & ADDR_MASK;
        bus.mem_wstrb = lat_wstrb;
        bus.mem_wdata = lat_wdata;
        bus.c_gnt     = ~owner_q;
        bus.d_gnt     = owner_q;
        state_nx      = RESPOND;
      end

      RESPOND: begin
        bus.busy = 1'b1;
        // Write acknowledges carry zero data.
        if (owner_q) begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = lat_we ? '0 : bus.mem_rdata;
        end else begin
          bus.c_rvalid = 1'b1;
          bus.c_rdata  = lat_we ? '0 : bus.mem_rdata;
        end
        state_nx = take ? ACCESS : IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Self-checking bench for memory_arbiter. A small word memory answers the
//   arbiter's memory port with one cycle of read latency. A table of
//   per-cycle {inputs, expected outputs} records covers isolated reads,
//   full/partial/zero-strobe writes and address alignment; hand-written
//   sequences cover contention from reset, reset during ACCESS and
//   requests raised only during ACCESS.
module tb_memory_arbiter;
  logic clk;
  logic rst_n;

  memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [3:0]  c_wstrb;
    logic [31:0] c_wdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
  } in_t;

  typedef struct packed {
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        owner;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  int test_count = 0;
  int fail_count = 0;

  // Memory model with a backdoor for preloading.
  logic [31:0] mem [0:63];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_wstrb[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end
      bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end
  end

  function automatic in_t core_in(logic we, logic [31:0] addr, logic [3:0] strb, logic [31:0] data);
    in_t v = '0;
    v.c_req = 1'b1; v.c_we = we; v.c_addr = addr; v.c_wstrb = strb; v.c_wdata = data;
    return v;
  endfunction

  function automatic in_t dbg_in(logic we, logic [31:0] addr, logic [3:0] strb, logic [31:0] data);
    in_t v = '0;
    v.d_req = 1'b1; v.d_we = we; v.d_addr = addr; v.d_wstrb = strb; v.d_wdata = data;
    return v;
  endfunction

  function automatic out_t exp_idle(logic own);
    out_t o = '0;
    o.owner = own;
    return o;
  endfunction

  function automatic out_t exp_access(logic port, logic we, logic [31:0] addr, logic [3:0] strb, logic [31:0] data);
    out_t o = '0;
    if (port) o.d_gnt = 1'b1; else o.c_gnt = 1'b1;
    o.mem_en = 1'b1; o.mem_we = we; o.mem_addr = addr; o.mem_wstrb = strb; o.mem_wdata = data;
    o.busy = 1'b1; o.owner = port;
    return o;
  endfunction

  function automatic out_t exp_respond(logic port, logic [31:0] rdata);
    out_t o = '0;
    if (port) begin o.d_rvalid = 1'b1; o.d_rdata = rdata; end
    else      begin o.c_rvalid = 1'b1; o.c_rdata = rdata; end
    o.busy = 1'b1; o.owner = port;
    return o;
  endfunction

  function automatic out_t get_outputs();
    out_t o;
    o.c_gnt = bus.c_gnt; o.c_rvalid = bus.c_rvalid; o.c_rdata = bus.c_rdata;
    o.d_gnt = bus.d_gnt; o.d_rvalid = bus.d_rvalid; o.d_rdata = bus.d_rdata;
    o.mem_en = bus.mem_en; o.mem_we = bus.mem_we; o.mem_addr = bus.mem_addr;
    o.mem_wstrb = bus.mem_wstrb; o.mem_wdata = bus.mem_wdata;
    o.busy = bus.busy; o.owner = bus.owner;
    return o;
  endfunction

  task automatic apply_stimulus(input in_t v);
    bus.c_req = v.c_req; bus.c_we = v.c_we; bus.c_addr = v.c_addr;
    bus.c_wstrb = v.c_wstrb; bus.c_wdata = v.c_wdata;
    bus.d_req = v.d_req; bus.d_we = v.d_we; bus.d_addr = v.d_addr;
    bus.d_wstrb = v.d_wstrb; bus.d_wdata = v.d_wdata;
  endtask

  task automatic check_output(input string name, input out_t exp);
    out_t act;
    act = get_outputs();
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_idx = 6'(idx); bd_data = val; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Holds reset for two cycles with the given inputs, checks the reset
  // state, then releases mid-cycle so the next rising edge is the first
  // that samples requests.
  task automatic do_reset(input in_t v, input string name);
    apply_stimulus(v);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output(name, exp_idle(1'b0));
    rst_n = 1'b1;
  endtask

  vec_t vecs [17];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    apply_stimulus('0);
    preload(11, 32'hdeadbeef);
    preload(12, 32'h5a5a5a5a);
    preload(13, 32'hcafebabe);
    preload(2,  32'h0badf00d);

    vecs[0]  = '{core_in(1'b0, 32'd44, 4'h0, 32'h0),          exp_idle(1'b0)};
    vecs[1]  = '{core_in(1'b0, 32'd44, 4'h0, 32'h0),          exp_access(1'b0, 1'b0, 32'd44, 4'h0, 32'h0)};
    vecs[2]  = '{in_t'('0),                                    exp_respond(1'b0, 32'hdeadbeef)};
    vecs[3]  = '{in_t'('0),                                    exp_idle(1'b0)};
    vecs[4]  = '{core_in(1'b1, 32'd48, 4'hf, 32'd256),        exp_idle(1'b0)};
    vecs[5]  = '{core_in(1'b1, 32'd48, 4'hf, 32'd256),        exp_access(1'b0, 1'b1, 32'd48, 4'hf, 32'd256)};
    vecs[6]  = '{in_t'('0),                                    exp_respond(1'b0, 32'h0)};
    vecs[7]  = '{dbg_in(1'b1, 32'd55, 4'h3, 32'h00001234),    exp_idle(1'b0)};
    vecs[8]  = '{dbg_in(1'b1, 32'd55, 4'h3, 32'h00001234),    exp_access(1'b1, 1'b1, 32'd52, 4'h3, 32'h00001234)};
    vecs[9]  = '{in_t'('0),                                    exp_respond(1'b1, 32'h0)};
    vecs[10] = '{dbg_in(1'b0, 32'd52, 4'h0, 32'h0),           exp_idle(1'b1)};
    vecs[11] = '{dbg_in(1'b0, 32'd52, 4'h0, 32'h0),           exp_access(1'b1, 1'b0, 32'd52, 4'h0, 32'h0)};
    vecs[12] = '{in_t'('0),                                    exp_respond(1'b1, 32'hcafe1234)};
    vecs[13] = '{core_in(1'b1, 32'd44, 4'h0, 32'hffffffff),   exp_idle(1'b1)};
    vecs[14] = '{core_in(1'b1, 32'd44, 4'h0, 32'hffffffff),   exp_access(1'b0, 1'b1, 32'd44, 4'h0, 32'hffffffff)};
    vecs[15] = '{in_t'('0),                                    exp_respond(1'b0, 32'h0)};
    vecs[16] = '{in_t'('0),                                    exp_idle(1'b0)};

    do_reset('0, "reset_state");
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i].stim);
      #1;
      check_output($sformatf("vec%0d", i), vecs[i].exp);
    end
    check_val("mem11_zero_strobe", mem[11], 32'hdeadbeef);
    check_val("mem12_full_write",  mem[12], 32'h00000100);
    check_val("mem13_partial",     mem[13], 32'hcafe1234);

    // Contention from reset release: core, debug, core, debug, no IDLE gap.
    begin
      in_t both;
      both = core_in(1'b0, 32'd0, 4'h0, 32'h0) | dbg_in(1'b0, 32'd4, 4'h0, 32'h0);
      do_reset(both, "contention_reset");
      for (int k = 1; k <= 8; k++) begin
        logic [3:0] exp4;
        logic [3:0] act4;
        @(negedge clk);
        #1;
        exp4 = {(k == 1 || k == 5), (k == 3 || k == 7), 1'b1, 1'(((k - 1) / 2) % 2)};
        act4 = {bus.c_gnt, bus.d_gnt, bus.busy, bus.owner};
        check_val($sformatf("contention_cyc%0d", k), 32'(act4), 32'(exp4));
      end
    end

    // Reset asserted during ACCESS of a core write: outputs drop at once,
    // the write never lands, and the core wins the first tie afterwards.
    do_reset('0, "midop_pre_reset");
    @(negedge clk);
    apply_stimulus(core_in(1'b1, 32'd44, 4'hf, 32'h11111111));
    @(negedge clk);
    #1;
    check_val("midop_access_gnt", 32'(bus.c_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("midop_reset_now", exp_idle(1'b0));
    apply_stimulus(core_in(1'b0, 32'd0, 4'h0, 32'h0) | dbg_in(1'b0, 32'd4, 4'h0, 32'h0));
    @(negedge clk);
    #1;
    check_output("midop_reset_hold", exp_idle(1'b0));
    check_val("midop_mem11", mem[11], 32'hdeadbeef);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_val("midop_core_first", 32'({bus.c_gnt, bus.d_gnt}), 32'h2);

    // Debug request raised only during ACCESS is ignored.
    do_reset('0, "late_pre_reset");
    @(negedge clk);
    apply_stimulus(core_in(1'b0, 32'd44, 4'h0, 32'h0));
    @(negedge clk);
    apply_stimulus(core_in(1'b0, 32'd44, 4'h0, 32'h0) | dbg_in(1'b0, 32'd8, 4'h0, 32'h0));
    #1;
    check_val("late_core_gnt", 32'(bus.c_gnt), 32'd1);
    @(negedge clk);
    apply_stimulus('0);
    #1;
    check_output("late_core_resp", exp_respond(1'b0, 32'hdeadbeef));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("late_no_dgnt%0d", k), 32'({bus.d_gnt, bus.busy}), 32'h0);
    end

    // Debug request held through RESPOND is granted back-to-back.
    @(negedge clk);
    apply_stimulus(core_in(1'b0, 32'd44, 4'h0, 32'h0));
    @(negedge clk);
    apply_stimulus(core_in(1'b0, 32'd44, 4'h0, 32'h0) | dbg_in(1'b0, 32'd8, 4'h0, 32'h0));
    @(negedge clk);
    apply_stimulus(dbg_in(1'b0, 32'd8, 4'h0, 32'h0));
    #1;
    check_output("b2b_core_resp", exp_respond(1'b0, 32'hdeadbeef));
    @(negedge clk);
    apply_stimulus(dbg_in(1'b0, 32'd8, 4'h0, 32'h0));
    #1;
    check_output("b2b_dbg_access", exp_access(1'b1, 1'b0, 32'd8, 4'h0, 32'h0));
    @(negedge clk);
    apply_stimulus('0);
    #1;
    check_output("b2b_dbg_resp", exp_respond(1'b1, 32'h0badf00d));
    @(negedge clk);
    #1;
    check_output("b2b_idle", exp_idle(1'b1));

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
